// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master port between the icache and dcache.
// Reads are arbitrated onto AR/R, dcache write-backs go to AW/W/B, and dcache reads that hit an in-flight write-back line are held off.
module cache_axi_arbiter #(
    parameter int LINE_OFS = 6
) (
    input  logic        clk,
    input  logic        rst,

    // icache read port
    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic [2:0]  i_r_size,
    input  logic [7:0]  i_r_length,
    output logic        i_r_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_r_data,
    input  logic        i_r_data_ready,

    // dcache read port
    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic [2:0]  d_r_size,
    input  logic [7:0]  d_r_length,
    output logic        d_r_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_r_data,
    input  logic        d_r_data_ready,

    // dcache write port
    input  logic        d_w_req,
    input  logic [31:0] d_w_addr,
    input  logic [2:0]  d_w_size,
    input  logic [7:0]  d_w_length,
    output logic        d_w_rdy,
    input  logic        d_w_data_req,
    input  logic [31:0] d_w_data,
    input  logic [3:0]  d_w_strb,
    input  logic        d_w_last,
    output logic        d_w_data_ready,
    output logic        d_b_valid,
    input  logic        d_b_ready,

    // AXI4 read address / data
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // AXI4 write address / data / response
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [1:0]  r_state;
    logic        r_owner_d;
    logic        fair;
    logic [31:0] ar_addr_q;
    logic [7:0]  ar_len_q;
    logic [2:0]  ar_size_q;

    logic [1:0]  w_state;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic [2:0]  aw_size_q;
    logic [7:0]  beat_cnt;

    logic        raw_block;
    logic        d_elig;
    logic        grant_i;
    logic        grant_d;
    logic        unused_w_last;

    // wlast comes from the beat counter, so the requester's own last flag is not needed.
    assign unused_w_last = d_w_last;

    // A dcache read must not overtake a write-back to the same line.
    assign raw_block = (w_state != W_IDLE) &&
                       (d_r_addr[31:LINE_OFS] == aw_addr_q[31:LINE_OFS]);
    assign d_elig    = d_r_req && !raw_block;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (r_state == R_IDLE) begin
            if (d_elig && (!i_r_req || !fair)) begin
                grant_d = 1'b1;
            end else if (i_r_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_owner_d <= 1'b0;
            fair      <= 1'b0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
        end else begin
            if (grant_i) begin
                fair <= 1'b0;
            end else if (grant_d && i_r_req) begin
                fair <= 1'b1;
            end

            case (r_state)
                R_IDLE: begin
                    if (grant_d) begin
                        r_owner_d <= 1'b1;
                        ar_addr_q <= d_r_addr;
                        ar_len_q  <= d_r_length;
                        ar_size_q <= d_r_size;
                        r_state   <= R_ADDR;
                    end else if (grant_i) begin
                        r_owner_d <= 1'b0;
                        ar_addr_q <= i_r_addr;
                        ar_len_q  <= i_r_length;
                        ar_size_q <= i_r_size;
                        r_state   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arready) begin
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready && rlast) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign arvalid = (r_state == R_ADDR);
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;

    assign i_r_rdy = arvalid && arready && !r_owner_d;
    assign d_r_rdy = arvalid && arready &&  r_owner_d;

    // R beats pass straight through; only the owner sees them.
    assign i_ret_valid = (r_state == R_DATA) && !r_owner_d && rvalid;
    assign i_ret_last  = (r_state == R_DATA) && !r_owner_d && rlast;
    assign d_ret_valid = (r_state == R_DATA) &&  r_owner_d && rvalid;
    assign d_ret_last  = (r_state == R_DATA) &&  r_owner_d && rlast;
    assign i_r_data    = rdata;
    assign d_r_data    = rdata;
    assign rready      = (r_state == R_DATA) &&
                         (r_owner_d ? d_r_data_ready : i_r_data_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_size_q <= '0;
            beat_cnt  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (d_w_req) begin
                        aw_addr_q <= d_w_addr;
                        aw_len_q  <= d_w_length;
                        aw_size_q <= d_w_size;
                        beat_cnt  <= '0;
                        w_state   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (awready) begin
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (wlast) begin
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && d_b_ready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign awvalid = (w_state == W_ADDR);
    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awsize  = aw_size_q;
    assign d_w_rdy = awvalid && awready;

    assign wvalid         = (w_state == W_DATA) && d_w_data_req;
    assign wlast          = (w_state == W_DATA) && (beat_cnt == aw_len_q);
    assign wdata          = d_w_data;
    assign wstrb          = d_w_strb;
    assign d_w_data_ready = (w_state == W_DATA) && wready;

    assign d_b_valid = (w_state == W_RESP) && bvalid;
    assign bready    = (w_state == W_RESP) && d_b_ready;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: the AXI slave and both caches are driven step by step,
// with expected AR grants, read beats and write beats held in scoreboard queues.
module tb_cache_axi_arbiter;

    logic        clk;
    logic        rst;

    logic        i_r_req, d_r_req;
    logic [31:0] i_r_addr, d_r_addr;
    logic [2:0]  i_r_size, d_r_size;
    logic [7:0]  i_r_length, d_r_length;
    logic        i_r_rdy, d_r_rdy;
    logic        i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0] i_r_data, d_r_data;
    logic        i_r_data_ready, d_r_data_ready;

    logic        d_w_req;
    logic [31:0] d_w_addr;
    logic [2:0]  d_w_size;
    logic [7:0]  d_w_length;
    logic        d_w_rdy;
    logic        d_w_data_req;
    logic [31:0] d_w_data;
    logic [3:0]  d_w_strb;
    logic        d_w_last;
    logic        d_w_data_ready;
    logic        d_b_valid;
    logic        d_b_ready;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    typedef struct {
        bit          own_d;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wbeat_t;

    ar_exp_t ar_q[$];
    rbeat_t  rd_q[$];
    wbeat_t  w_q[$];

    int checks = 0;
    int errors = 0;

    cache_axi_arbiter #(.LINE_OFS(6)) dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_length(i_r_length),
        .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_r_data(i_r_data), .i_r_data_ready(i_r_data_ready),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_size(d_r_size), .d_r_length(d_r_length),
        .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_r_data(d_r_data), .d_r_data_ready(d_r_data_ready),
        .d_w_req(d_w_req), .d_w_addr(d_w_addr), .d_w_size(d_w_size), .d_w_length(d_w_length),
        .d_w_rdy(d_w_rdy), .d_w_data_req(d_w_data_req), .d_w_data(d_w_data), .d_w_strb(d_w_strb),
        .d_w_last(d_w_last), .d_w_data_ready(d_w_data_ready), .d_b_valid(d_b_valid),
        .d_b_ready(d_b_ready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "bench watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input bit own_d, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
        ar_exp_t e;
        e.own_d = own_d;
        e.addr  = addr;
        e.len   = len;
        e.size  = size;
        ar_q.push_back(e);
    endtask

    // Waits for the next AR handshake and compares it with the scoreboard head.
    task automatic wait_ar(input int max_cyc);
        ar_exp_t e;
        bit seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            arready = 1'b1;
            #1;
            if (arvalid) begin
                seen = 1'b1;
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 32'd1, 32'd0);
                end else begin
                    e = ar_q.pop_front();
                    check("ar_addr", araddr, e.addr);
                    check("ar_len", {24'd0, arlen}, {24'd0, e.len});
                    check("ar_size", {29'd0, arsize}, {29'd0, e.size});
                    check("d_r_rdy", {31'd0, d_r_rdy}, {31'd0, e.own_d});
                    check("i_r_rdy", {31'd0, i_r_rdy}, {31'd0, !e.own_d});
                    if (e.own_d) d_r_req = 1'b0;
                    else         i_r_req = 1'b0;
                end
            end
            next();
        end
        if (!seen) check("ar_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_burst(input bit own_d, input int nbeats, input bit toggle);
        rbeat_t      exp_b;
        int          hs = 0;
        int          cyc = 0;
        bit          fresh = 1'b1;
        logic        rdy;
        logic [31:0] dat = '0;
        while (hs < nbeats && cyc < 200) begin
            if (fresh) begin
                dat = $urandom;
                exp_b.data = dat;
                exp_b.last = (hs == nbeats - 1);
                rd_q.push_back(exp_b);
                fresh = 1'b0;
            end
            rdy    = toggle ? (cyc % 2 == 1) : 1'b1;
            rvalid = 1'b1;
            rdata  = dat;
            rlast  = (hs == nbeats - 1);
            if (own_d) begin
                d_r_data_ready = rdy;
                i_r_data_ready = 1'b1;
            end else begin
                i_r_data_ready = rdy;
                d_r_data_ready = 1'b1;
            end
            #1;
            check("owner_ret_valid", {31'd0, own_d ? d_ret_valid : i_ret_valid}, 32'd1);
            check("other_ret_valid", {31'd0, own_d ? i_ret_valid : d_ret_valid}, 32'd0);
            check("rready", {31'd0, rready}, {31'd0, rdy});
            if (rvalid && rready) begin
                exp_b = rd_q.pop_front();
                check("r_data", own_d ? d_r_data : i_r_data, exp_b.data);
                check("ret_last", {31'd0, own_d ? d_ret_last : i_ret_last}, {31'd0, exp_b.last});
                hs++;
                fresh = 1'b1;
            end
            next();
            cyc++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("read_beats", hs, nbeats);
    endtask

    task automatic write_burst(input int nbeats, input bit toggle, input bit ar_low,
                               input logic [3:0] strb);
        wbeat_t      exp_b;
        int          hs = 0;
        int          cyc = 0;
        bit          fresh = 1'b1;
        logic [31:0] dat = '0;
        while (hs < nbeats && cyc < 200) begin
            if (fresh) begin
                dat = $urandom;
                exp_b.data = dat;
                exp_b.strb = strb;
                exp_b.last = (hs == nbeats - 1);
                w_q.push_back(exp_b);
                fresh = 1'b0;
            end
            d_w_data_req = 1'b1;
            d_w_data     = dat;
            d_w_strb     = strb;
            d_w_last     = 1'b0;
            wready       = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            check("wvalid", {31'd0, wvalid}, 32'd1);
            check("d_w_data_ready", {31'd0, d_w_data_ready}, {31'd0, wready});
            if (ar_low) check("raw_ar_blocked", {31'd0, arvalid}, 32'd0);
            if (wvalid && wready) begin
                exp_b = w_q.pop_front();
                check("wdata", wdata, exp_b.data);
                check("wstrb", {28'd0, wstrb}, {28'd0, exp_b.strb});
                check("wlast", {31'd0, wlast}, {31'd0, exp_b.last});
                hs++;
                fresh = 1'b1;
            end
            next();
            cyc++;
        end
        d_w_data_req = 1'b0;
        wready       = 1'b0;
        check("write_beats", hs, nbeats);
    endtask

    // B phase: idle cycle, stalled response, handshake, then confirm W_IDLE.
    task automatic b_phase(input bit ar_low);
        bvalid = 1'b0; d_b_ready = 1'b1;
        #1;
        check("b_valid_idle", {31'd0, d_b_valid}, 32'd0);
        check("bready_resp", {31'd0, bready}, 32'd1);
        if (ar_low) check("raw_ar_in_resp", {31'd0, arvalid}, 32'd0);
        next();
        bvalid = 1'b1; d_b_ready = 1'b0;
        #1;
        check("b_valid_follow", {31'd0, d_b_valid}, 32'd1);
        check("bready_stall", {31'd0, bready}, 32'd0);
        next();
        d_b_ready = 1'b1;
        #1;
        check("bready_hs", {31'd0, bready}, 32'd1);
        next();
        #1;
        check("b_valid_after_idle", {31'd0, d_b_valid}, 32'd0);
        if (ar_low) check("raw_ar_w_idle", {31'd0, arvalid}, 32'd0);
        bvalid = 1'b0; d_b_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_r_req = 0; i_r_addr = 0; i_r_size = 0; i_r_length = 0; i_r_data_ready = 1;
        d_r_req = 0; d_r_addr = 0; d_r_size = 0; d_r_length = 0; d_r_data_ready = 1;
        d_w_req = 0; d_w_addr = 0; d_w_size = 0; d_w_length = 0;
        d_w_data_req = 1; d_w_data = 0; d_w_strb = 0; d_w_last = 0; d_b_ready = 1;
        arready = 1; rdata = 32'hDEAD_BEEF; rlast = 1; rvalid = 1;
        awready = 1; wready = 1; bvalid = 1;

        // Reset with every slave-side handshake input asserted.
        next();
        next();
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_wlast", {31'd0, wlast}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        check("rst_r_rdy", {30'd0, i_r_rdy, d_r_rdy}, 32'd0);
        check("rst_ret", {28'd0, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 32'd0);
        check("rst_w_side", {29'd0, d_w_rdy, d_w_data_ready, d_b_valid}, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);

        rst = 1'b0;
        d_w_data_req = 0; d_b_ready = 0; rlast = 0; rvalid = 0; wready = 0; bvalid = 0;
        next();

        // Simultaneous requests: dcache first, icache next via the fairness bit.
        d_r_req = 1; d_r_addr = 32'h2000_0080; d_r_length = 8'd7; d_r_size = 3'd2;
        i_r_req = 1; i_r_addr = 32'h0000_1000; i_r_length = 8'd15; i_r_size = 3'd2;
        push_ar(1'b1, 32'h2000_0080, 8'd7, 3'd2);
        push_ar(1'b0, 32'h0000_1000, 8'd15, 3'd2);
        #1;
        check("sim_ar_idle", {31'd0, arvalid}, 32'd0);
        next();
        wait_ar(1);
        d_r_req = 1; d_r_addr = 32'h2000_00C0; d_r_length = 8'd0; d_r_size = 3'd2;
        read_burst(1'b1, 8, 1'b0);
        #1;
        check("b2b_gap", {31'd0, arvalid}, 32'd0);
        next();
        wait_ar(1);

        // 16-beat icache burst with toggling ready while dcache waits.
        push_ar(1'b1, 32'h2000_00C0, 8'd0, 3'd2);
        read_burst(1'b0, 16, 1'b1);
        wait_ar(4);
        read_burst(1'b1, 1, 1'b0);

        // Write-back of 0x1C000040 with a same-line dcache read held off.
        d_w_req = 1; d_w_addr = 32'h1C00_0040; d_w_length = 8'd15; d_w_size = 3'd2;
        awready = 0;
        #1;
        check("aw_idle", {31'd0, awvalid}, 32'd0);
        next();
        #1;
        check("aw_valid", {31'd0, awvalid}, 32'd1);
        check("aw_addr", awaddr, 32'h1C00_0040);
        check("aw_len", {24'd0, awlen}, 32'd15);
        check("w_rdy_stall", {31'd0, d_w_rdy}, 32'd0);
        d_r_req = 1; d_r_addr = 32'h1C00_0044; d_r_length = 8'd3; d_r_size = 3'd2;
        next();
        awready = 1;
        #1;
        check("raw_ar_addr_phase", {31'd0, arvalid}, 32'd0);
        check("aw_stable_valid", {31'd0, awvalid}, 32'd1);
        check("aw_stable_addr", awaddr, 32'h1C00_0040);
        check("w_rdy_pulse", {31'd0, d_w_rdy}, 32'd1);
        d_w_req = 0;
        next();
        i_r_req = 1; i_r_addr = 32'h0000_1000; i_r_length = 8'd0; i_r_size = 3'd2;
        push_ar(1'b0, 32'h0000_1000, 8'd0, 3'd2);
        #1;
        check("raw_ar_data_phase", {31'd0, arvalid}, 32'd0);
        next();
        wait_ar(1);
        read_burst(1'b0, 1, 1'b0);
        write_burst(16, 1'b1, 1'b1, 4'hF);
        b_phase(1'b1);
        push_ar(1'b1, 32'h1C00_0044, 8'd3, 3'd2);
        next();
        wait_ar(1);
        read_burst(1'b1, 4, 1'b1);

        // Uncached single-beat store alongside an icache burst.
        i_r_req = 1; i_r_addr = 32'h0000_2000; i_r_length = 8'd7; i_r_size = 3'd2;
        d_w_req = 1; d_w_addr = 32'h8000_0010; d_w_length = 8'd0; d_w_size = 3'd2;
        push_ar(1'b0, 32'h0000_2000, 8'd7, 3'd2);
        next();
        #1;
        check("conc_awvalid", {31'd0, awvalid}, 32'd1);
        check("conc_w_rdy", {31'd0, d_w_rdy}, 32'd1);
        check("conc_awlen", {24'd0, awlen}, 32'd0);
        d_w_req = 0;
        wait_ar(1);
        write_burst(1, 1'b0, 1'b0, 4'b0010);
        bvalid = 1; d_b_ready = 1;
        #1;
        check("conc_b_valid", {31'd0, d_b_valid}, 32'd1);
        check("conc_bready", {31'd0, bready}, 32'd1);
        read_burst(1'b0, 8, 1'b0);
        #1;
        check("conc_w_idle", {31'd0, d_b_valid}, 32'd0);
        bvalid = 0; d_b_ready = 0;

        // Reset on beat 5 of an icache burst.
        i_r_req = 1; i_r_addr = 32'h0000_3000; i_r_length = 8'd15; i_r_size = 3'd2;
        push_ar(1'b0, 32'h0000_3000, 8'd15, 3'd2);
        next();
        wait_ar(1);
        for (int k = 0; k < 4; k++) begin
            rvalid = 1; rlast = 0; rdata = k; i_r_data_ready = 1;
            #1;
            check("pre_rst_rready", {31'd0, rready}, 32'd1);
            next();
        end
        rvalid = 1; rdata = 32'd4; rst = 1;
        wready = 1; bvalid = 1; d_b_ready = 1; d_w_data_req = 1;
        #1;
        check("beat5_valid", {31'd0, i_ret_valid}, 32'd1);
        next();
        check("mid_rst_rready", {31'd0, rready}, 32'd0);
        check("mid_rst_ret_valid", {31'd0, i_ret_valid}, 32'd0);
        check("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("mid_rst_w_side", {27'd0, awvalid, wvalid, bready, d_b_valid, d_w_data_ready}, 32'd0);
        rst = 0; rvalid = 0; wready = 0; bvalid = 0; d_b_ready = 0; d_w_data_req = 0;
        rd_q.delete();
        d_r_req = 1; d_r_addr = 32'h0000_4000; d_r_length = 8'd0; d_r_size = 3'd2;
        i_r_req = 1; i_r_addr = 32'h0000_5000; i_r_length = 8'd0; i_r_size = 3'd2;
        push_ar(1'b1, 32'h0000_4000, 8'd0, 3'd2);
        push_ar(1'b0, 32'h0000_5000, 8'd0, 3'd2);
        wait_ar(2);
        read_burst(1'b1, 1, 1'b0);
        wait_ar(3);
        read_burst(1'b0, 1, 1'b0);

        check("ar_queue_empty", ar_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Sits between the two L1 caches and the single AXI4 master port, directly downstream of the data cache. It arbitrates icache and dcache read bursts onto one AR/R channel pair and forwards dcache write-backs and uncached stores onto AW/W/B. It also blocks a dcache read that targets a line whose write-back is still in flight. There is one read and one write transaction outstanding at most; reads and writes proceed concurrently.

## Interface
- LINE_OFS, default 6: line offset bits used for the read-after-write line compare.
- clk  in  1  single clock. Synchronous, active-high reset; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- {i,d}_r_req  in  1  read request; held until the matching {i,d}_r_rdy.
- {i,d}_r_addr / _r_size / _r_length  in  32/3/8  read start address, AXI size, AXI len (beats-1).
- {i,d}_r_rdy  out  1  one-cycle pulse when the requester's AR handshake completes.
- {i,d}_ret_valid / _ret_last  out  1  returned beat valid / last beat.
- {i,d}_r_data  out  32  returned data (rdata fan-out).
- {i,d}_r_data_ready  in  1  requester accepts the beat.
- d_w_req  in  1  write request.
- d_w_addr / d_w_size / d_w_length  in  32/3/8  write address, size, len.
- d_w_rdy  out  1  one-cycle pulse on the AW handshake.
- d_w_data_req  in  1  write beat valid.
- d_w_data / d_w_strb  in  32/4  write beat data and byte strobes.
- d_w_last  in  1  write last beat; ignored, because wlast is generated internally.
- d_w_data_ready  out  1  beat accepted.
- d_b_valid  out  1  write response valid.
- d_b_ready  in  1  write response accepted.
- araddr / arlen / arsize  out  32/8/3  AR payload.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  32  R data.
- rlast / rvalid  in  1  R last / R valid.
- rready  out  1  R ready.
- awaddr / awlen / awsize  out  32/8/3  AW payload.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wdata / wstrb  out  32/4  W data and strobes.
- wlast / wvalid  out  1  W last / W valid.
- wready  in  1  W ready.
- bvalid  in  1  B valid.
- bready  out  1  B ready.

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: choose an owner among eligible requests and latch the owner's addr/size/length into AR registers. Move to R_ADDR.
  - dcache wins a simultaneous request unless the fairness bit is set.
  - Fairness bit is set when dcache is granted while i_r_req is pending. It is cleared on any icache grant.
  - R_ADDR: arvalid=1 with the registered payload. On arvalid&arready, pulse the owner's r_rdy and move to R_DATA.
  - R_DATA: owner ret_valid=rvalid, ret_last=rlast, r_data=rdata, rready=owner r_data_ready. The non-owner's ret_valid is 0.
  - On rvalid&rready&rlast, return to R_IDLE.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: on d_w_req, latch addr/size/length and clear the beat counter. Move to W_ADDR.
  - W_ADDR: awvalid=1. On the handshake, pulse d_w_rdy and move to W_DATA.
  - W_DATA: wvalid=d_w_data_req, d_w_data_ready=wready, wlast=(cnt==awlen). The counter increments on each wvalid&wready.
  - The last beat handshake moves the FSM to W_RESP.
  - W_RESP: d_b_valid=bvalid, bready=d_b_ready. On the handshake, return to W_IDLE.
- RAW hazard: d_r_req is ineligible while the write FSM is not W_IDLE and d_r_addr[31:LINE_OFS]==awaddr[31:LINE_OFS]. icache may be granted meanwhile.
- Width rules:
  - 8-bit beat counter compared with awlen.
  - len 0 = single beat.
  - Lengths are passed unchanged.
- Requests are sampled only in the IDLE states. Deasserting a request before r_rdy/w_rdy is illegal.

## Timing
- Reset values:
  - both FSMs IDLE; fairness bit 0; counter 0; payload registers 0.
  - arvalid, awvalid, wvalid, wlast, rready, bready, all r_rdy, ret_valid, ret_last, d_w_rdy, d_w_data_ready and d_b_valid are 0.
- Reset mid-burst aborts immediately to IDLE; the slave is reset in the same cycle.
- Latency:
  - Request seen in IDLE at cycle N → arvalid/awvalid at N+1.
  - r_rdy/w_rdy arrive in the same cycle as arready/awready, at N+1 at the earliest.
- R and W beats forward combinationally with zero added latency. Backpressure passes straight through.
- Back-to-back reads: rlast handshake at M → IDLE at M+1 → next arvalid at M+2.
- arvalid and the AR payload stay stable until arready; the same holds for AW.
- A hazard-blocked dcache read is granted at the earliest in the cycle after the write FSM reaches W_IDLE.

## Test plan
- **Simultaneous requests:** d_r_req and i_r_req both high with arready=1 → arvalid at N+1 with the dcache address, d_r_rdy pulses, i_r_rdy stays 0. The next grant goes to icache even if d_r_req is re-asserted.
- **Burst with backpressure:** 16-beat read (len=15) with r_data_ready toggling every cycle → exactly 16 data handshakes, ret_last only on beat 16, the non-owner sees ret_valid=0.
- **Write-back:** write-back of 0x1C000040, len=15, with d_w_last held 0 → wlast on beat 16 only, then W_RESP. d_b_valid follows bvalid, and W_IDLE is reached after the bready handshake.
- **RAW block:** dcache read of 0x1C000044 during a write to 0x1C000040 → arvalid stays 0 until the B handshake. An icache read of 0x00001000 issued meanwhile is granted.
- **Concurrent traffic:** an uncached single-beat write (len=0, strb=4'b0010) runs concurrently with an icache burst → both complete and wlast is asserted on the first beat.
- **Reset mid-burst:** rst during R_DATA beat 5 → all valid/ready outputs 0 the next cycle; a new request is granted normally afterwards.
